// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Load/store stage between ex_mem and mem_wb. Non-memory ops pass straight
// through combinationally. A load or store runs one request/valid handshake
// on the data memory port. This stage also does:
//   - byte-lane steering of the store data and byte enables
//   - sign or zero extension of load data
//   - detection of misaligned accesses and of memory timeouts
// stall_req holds the pipeline while an access is in flight.
//
// Ports
//   clk, rst              core clock; asynchronous active-low reset
//   mem_valid_i           op is a load/store
//   mem_rw_i              1 = store, 0 = load
//   mem_size_i            00 byte, 01 half, 10 word, 11 dword
//   mem_unsigned_i        load zero-extends when 1, sign-extends when 0
//   result_i              ALU result / effective address
//   store_data_i          right-aligned store data
//   reg_write_addr_i/_o   destination register (passed through)
//   reg_write_enable_i/_o destination write enable
//   stall_i               hold this stage while in DONE
//   result_o              value to mem_wb
//   stall_req             stall request to pipeline control
//   misalign_o, timeout_o error flags, high while in DONE
//   data_mem_*            registered request side of the data memory port
//   data_mem_valid/rdata  memory response
//
// State table
//   IDLE | no access in flight; pass-through or launch a new access
//   BUSY | request presented, waiting for data_mem_valid or timeout
//   DONE | access finished; present load data or error for one cycle
// ---------------------------------------------------------------------------
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_rw_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [63:0] result_i,
  input  logic [63:0] store_data_i,
  input  logic [4:0]  reg_write_addr_i,
  input  logic        reg_write_enable_i,
  input  logic        stall_i,
  output logic [63:0] result_o,
  output logic [4:0]  reg_write_addr_o,
  output logic        reg_write_enable_o,
  output logic        stall_req,
  output logic        misalign_o,
  output logic        timeout_o,
  output logic        data_mem_req,
  output logic        data_mem_rw,
  output logic [63:0] data_mem_addr,
  output logic [63:0] data_mem_wdata,
  output logic [7:0]  data_mem_wstrb,
  input  logic        data_mem_valid,
  input  logic [63:0] data_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_req;
  logic        r_rw;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [63:0] r_load;
  logic [15:0] r_cnt;
  logic        r_misalign;
  logic        r_timeout;

  logic [2:0]  w_off;
  logic [5:0]  w_shamt;
  logic        w_misaligned;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_rshift;
  logic [63:0] w_load_ext;
  logic [15:0] w_cnt_inc;
  logic        w_timeout_hit;

  // Byte offset within the aligned 8-byte word; the shift amount is in bits.
  assign w_off   = result_i[2:0];
  assign w_shamt = {w_off, 3'b000};
  assign w_wdata = store_data_i << w_shamt;
  assign w_rshift = data_mem_rdata >> w_shamt;

  // The counter value after this BUSY cycle is compared against the limit,
  // so the request is held for exactly TIMEOUT_CYCLES BUSY cycles.
  assign w_cnt_inc     = r_cnt + 16'd1;
  assign w_timeout_hit = (w_cnt_inc == 16'(TIMEOUT_CYCLES));

  always_comb begin
    w_misaligned = 1'b0;
    case (mem_size_i)
      2'b01:   w_misaligned = result_i[0];
      2'b10:   w_misaligned = |result_i[1:0];
      2'b11:   w_misaligned = |result_i[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_wstrb = 8'h00;
    case (mem_size_i)
      2'b00:   w_wstrb = 8'h01 << w_off;
      2'b01:   w_wstrb = 8'h03 << w_off;
      2'b10:   w_wstrb = 8'h0F << w_off;
      default: w_wstrb = 8'hFF;
    endcase
  end

  always_comb begin
    w_load_ext = w_rshift;
    case (mem_size_i)
      2'b00: w_load_ext = mem_unsigned_i ? {56'd0, w_rshift[7:0]}
                                         : {{56{w_rshift[7]}}, w_rshift[7:0]};
      2'b01: w_load_ext = mem_unsigned_i ? {48'd0, w_rshift[15:0]}
                                         : {{48{w_rshift[15]}}, w_rshift[15:0]};
      2'b10: w_load_ext = mem_unsigned_i ? {32'd0, w_rshift[31:0]}
                                         : {{32{w_rshift[31]}}, w_rshift[31:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    result_o           = result_i;
    reg_write_enable_o = reg_write_enable_i;
    stall_req          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_valid_i) begin
          stall_req          = 1'b1;
          reg_write_enable_o = 1'b0;
          w_state_next       = w_misaligned ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_req          = 1'b1;
        reg_write_enable_o = 1'b0;
        // A response arriving on the timeout edge still completes the access.
        if (data_mem_valid || w_timeout_hit) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_misalign || r_timeout) begin
          result_o           = 64'd0;
          reg_write_enable_o = 1'b0;
        end else if (mem_rw_i) begin
          reg_write_enable_o = 1'b0;
        end else begin
          result_o = r_load;
        end
        if (!stall_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_rw       <= 1'b0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_wstrb    <= 8'h00;
      r_load     <= 64'd0;
      r_cnt      <= 16'd0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_valid_i) begin
            if (w_misaligned) begin
              r_misalign <= 1'b1;
            end else begin
              r_req   <= 1'b1;
              r_rw    <= mem_rw_i;
              r_addr  <= {result_i[63:3], 3'b000};
              r_wdata <= w_wdata;
              r_wstrb <= w_wstrb;
              r_cnt   <= 16'd0;
            end
          end
        end
        ST_BUSY: begin
          if (data_mem_valid) begin
            r_req  <= 1'b0;
            r_load <= w_load_ext;
          end else if (w_timeout_hit) begin
            r_req     <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_DONE: begin
          if (!stall_i) begin
            r_cnt      <= 16'd0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        default: begin
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign reg_write_addr_o = reg_write_addr_i;
  assign misalign_o       = r_misalign;
  assign timeout_o        = r_timeout;
  assign data_mem_req     = r_req;
  assign data_mem_rw      = r_rw;
  assign data_mem_addr    = r_addr;
  assign data_mem_wdata   = r_wdata;
  assign data_mem_wstrb   = r_wstrb;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic        mem_rw_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [63:0] result_i;
  logic [63:0] store_data_i;
  logic [4:0]  reg_write_addr_i;
  logic        reg_write_enable_i;
  logic        stall_i;
  logic [63:0] result_o;
  logic [4:0]  reg_write_addr_o;
  logic        reg_write_enable_o;
  logic        stall_req;
  logic        misalign_o;
  logic        timeout_o;
  logic        data_mem_req;
  logic        data_mem_rw;
  logic [63:0] data_mem_addr;
  logic [63:0] data_mem_wdata;
  logic [7:0]  data_mem_wstrb;
  logic        data_mem_valid;
  logic [63:0] data_mem_rdata;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_rw_i           (mem_rw_i),
    .mem_size_i         (mem_size_i),
    .mem_unsigned_i     (mem_unsigned_i),
    .result_i           (result_i),
    .store_data_i       (store_data_i),
    .reg_write_addr_i   (reg_write_addr_i),
    .reg_write_enable_i (reg_write_enable_i),
    .stall_i            (stall_i),
    .result_o           (result_o),
    .reg_write_addr_o   (reg_write_addr_o),
    .reg_write_enable_o (reg_write_enable_o),
    .stall_req          (stall_req),
    .misalign_o         (misalign_o),
    .timeout_o          (timeout_o),
    .data_mem_req       (data_mem_req),
    .data_mem_rw        (data_mem_rw),
    .data_mem_addr      (data_mem_addr),
    .data_mem_wdata     (data_mem_wdata),
    .data_mem_wstrb     (data_mem_wstrb),
    .data_mem_valid     (data_mem_valid),
    .data_mem_rdata     (data_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [63:0] result;
    logic        we;
    logic        mis;
    logic        tmo;
    int          stall;
  } done_t;

  typedef struct {
    logic [63:0] addr;
    logic        rw;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          len;
  } req_t;

  done_t done_q[$];
  req_t  req_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_delay = 99;
  logic alu_chk = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay BUSY cycles of a live request.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    data_mem_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (data_mem_req) begin
        data_mem_valid = (busy_cnt == ack_delay);
        busy_cnt++;
      end else begin
        busy_cnt = 0;
        data_mem_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when the DUT issues a request or completes.
  initial begin
    req_t  cur;
    done_t e;
    int    stall_cnt;
    int    req_len;
    logic  prev_req;
    logic  we_bad;
    stall_cnt = 0;
    req_len = 0;
    prev_req = 1'b0;
    we_bad = 1'b0;
    cur = '{addr: 64'd0, rw: 1'b0, wdata: 64'd0, wstrb: 8'd0, len: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_cnt = 0;
        we_bad = 1'b0;
      end else if (stall_req) begin
        stall_cnt++;
        if (reg_write_enable_o) we_bad = 1'b1;
      end

      if (data_mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h expected no request", data_mem_addr);
          cur.len = -1;
        end else begin
          cur = req_q.pop_front();
          chk("req_addr", data_mem_addr, cur.addr);
          chk("req_rw", 64'(data_mem_rw), 64'(cur.rw));
          chk("req_wdata", data_mem_wdata, cur.wdata);
          chk("req_wstrb", 64'(data_mem_wstrb), 64'(cur.wstrb));
        end
        req_len = 1;
      end else if (data_mem_req) begin
        req_len++;
      end else if (prev_req) begin
        if (cur.len >= 0) chk("req_len", 64'(req_len), 64'(cur.len));
      end
      prev_req = data_mem_req;

      if (rst && ((mem_valid_i && !stall_req) || (!mem_valid_i && alu_chk))) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got result %h expected no completion", result_o);
        end else begin
          e = done_q.pop_front();
          chk($sformatf("result#%0d", e.tag), result_o, e.result);
          chk($sformatf("we#%0d", e.tag), 64'(reg_write_enable_o), 64'(e.we));
          chk($sformatf("misalign#%0d", e.tag), 64'(misalign_o), 64'(e.mis));
          chk($sformatf("timeout#%0d", e.tag), 64'(timeout_o), 64'(e.tmo));
          chk($sformatf("stall_cycles#%0d", e.tag), 64'(stall_cnt), 64'(e.stall));
          chk($sformatf("we_in_stall#%0d", e.tag), 64'(we_bad), 64'd0);
          chk($sformatf("req_low#%0d", e.tag), 64'(data_mem_req), 64'd0);
          chk($sformatf("waddr#%0d", e.tag), 64'(reg_write_addr_o), 64'(reg_write_addr_i));
          if (!mem_valid_i) chk($sformatf("alu_stall#%0d", e.tag), 64'(stall_req), 64'd0);
        end
        stall_cnt = 0;
        we_bad = 1'b0;
      end
    end
  end

  task automatic issue(logic rw, logic [1:0] sz, logic uns, logic [63:0] addr,
                       logic [63:0] sd, logic [63:0] rd, int dly, logic we);
    mem_valid_i        = 1'b1;
    mem_rw_i           = rw;
    mem_size_i         = sz;
    mem_unsigned_i     = uns;
    result_i           = addr;
    store_data_i       = sd;
    data_mem_rdata     = rd;
    ack_delay          = dly;
    reg_write_enable_i = we;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (mem_valid_i && !stall_req) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: got no completion within 50 cycles expected completion");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(int tag, logic [63:0] v, logic we);
    mem_valid_i        = 1'b0;
    result_i           = v;
    reg_write_enable_i = we;
    reg_write_addr_i   = 5'(tag + 3);
    alu_chk            = 1'b1;
    done_q.push_back(done_t'{tag, v, we, 1'b0, 1'b0, 0});
    @(posedge clk);
    #1;
    alu_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mem_valid_i = 1'b0;
    mem_rw_i = 1'b0;
    mem_size_i = 2'b00;
    mem_unsigned_i = 1'b0;
    result_i = 64'd0;
    store_data_i = 64'd0;
    reg_write_addr_i = 5'd7;
    reg_write_enable_i = 1'b0;
    stall_i = 1'b0;
    data_mem_rdata = 64'd0;

    #12;
    chk("rst_req", 64'(data_mem_req), 64'd0);
    chk("rst_addr", data_mem_addr, 64'd0);
    chk("rst_wstrb", 64'(data_mem_wstrb), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ALU pass-through
    alu_op(1, 64'h1234, 1'b1);
    alu_op(2, 64'hDEAD_0000_0000_BEEF, 1'b0);

    // Signed byte load, first-cycle ack
    issue(1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 1'b1);
    req_q.push_back(req_t'{64'h1000, 1'b0, 64'd0, 8'h08, 1});
    done_q.push_back(done_t'{3, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 1'b0, 2});
    wait_done();
    alu_op(4, 64'h55, 1'b1);

    // Half store at lane 6, ack after two waits
    issue(1'b1, 2'b01, 1'b0, 64'h2006, 64'hBEEF, 64'd0, 2, 1'b1);
    req_q.push_back(req_t'{64'h2000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0, 3});
    done_q.push_back(done_t'{5, 64'h2006, 1'b0, 1'b0, 1'b0, 4});
    wait_done();
    alu_op(6, 64'h66, 1'b1);

    // Misaligned word load: no request
    issue(1'b0, 2'b10, 1'b0, 64'h3002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    done_q.push_back(done_t'{7, 64'd0, 1'b0, 1'b1, 1'b0, 1});
    wait_done();
    alu_op(8, 64'h77, 1'b1);

    // Word store with no ack: timeout after 4 BUSY cycles
    issue(1'b1, 2'b10, 1'b0, 64'h3008, 64'h1122_3344, 64'd0, 99, 1'b1);
    req_q.push_back(req_t'{64'h3008, 1'b1, 64'h1122_3344, 8'h0F, 4});
    done_q.push_back(done_t'{9, 64'd0, 1'b0, 1'b0, 1'b1, 5});
    wait_done();
    alu_op(10, 64'h88, 1'b1);

    // Signed half load, DONE held one extra cycle by stall_i
    stall_i = 1'b1;
    issue(1'b0, 2'b01, 1'b0, 64'h5002, 64'd0, 64'hDEAD_BEEF_CAFE_8001, 0, 1'b1);
    req_q.push_back(req_t'{64'h5000, 1'b0, 64'd0, 8'h0C, 1});
    done_q.push_back(done_t'{11, 64'hFFFF_FFFF_FFFF_CAFE, 1'b1, 1'b0, 1'b0, 2});
    done_q.push_back(done_t'{12, 64'hFFFF_FFFF_FFFF_CAFE, 1'b1, 1'b0, 1'b0, 0});
    wait_done();
    stall_i = 1'b0;
    wait_done();
    alu_op(13, 64'h99, 1'b0);

    // Unsigned word load from the upper lane, one wait cycle
    issue(1'b0, 2'b10, 1'b1, 64'h6004, 64'd0, 64'h8765_4321_0000_0000, 1, 1'b1);
    req_q.push_back(req_t'{64'h6000, 1'b0, 64'd0, 8'hF0, 2});
    done_q.push_back(done_t'{14, 64'h0000_0000_8765_4321, 1'b1, 1'b0, 1'b0, 3});
    wait_done();
    alu_op(15, 64'hAA, 1'b1);

    // Misaligned dword store
    issue(1'b1, 2'b11, 1'b0, 64'h7004, 64'h1, 64'd0, 0, 1'b1);
    done_q.push_back(done_t'{16, 64'd0, 1'b0, 1'b1, 1'b0, 1});
    wait_done();
    alu_op(17, 64'hBB, 1'b1);

    // Reset during BUSY, then the same op reissues from IDLE
    issue(1'b0, 2'b11, 1'b0, 64'h4000, 64'd0, 64'h0123_4567_89AB_CDEF, 99, 1'b1);
    req_q.push_back(req_t'{64'h4000, 1'b0, 64'd0, 8'hFF, 1});
    req_q.push_back(req_t'{64'h4000, 1'b0, 64'd0, 8'hFF, 1});
    done_q.push_back(done_t'{18, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0, 2});
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    ack_delay = 0;
    #1;
    chk("req_drop_on_rst", 64'(data_mem_req), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_done();
    alu_op(19, 64'hCC, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
